mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Two-requester arbiter for the single unified instruction/data memory of the multi-cycle MIPS core. It shares the one memory port between the CPU's address path (PC or ALUOut, plus MemWrite) and a DMA/loader master. The CPU owns the port by default. DMA gets bounded bursts, with a starvation limit so a busy CPU cannot lock DMA out. The block sits between the core's memory-address mux and the Memory instance; `cpu_stall` freezes the control unit whenever the CPU is denied.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width
- `STARVE_LIMIT`, 8, number of contended CPU cycles before DMA is forced in (≥1)
- `BURST_LEN`, 4, maximum DMA beats per grant (≥1)

- `clk`  in  1  single clock, rising edge
- `reset`  in  1  synchronous, active-high
- `cpu_req`  in  1  CPU wants a memory access this cycle
- `cpu_we`  in  1  CPU access is a write
- `cpu_addr`  in  ADDR_W  CPU address
- `cpu_wdata`  in  DATA_W  CPU write data
- `cpu_rdata`  out  DATA_W  combinational read data, equal to `mem_rd`
- `cpu_stall`  out  1  CPU access is not serviced this cycle; core must hold its state
- `dma_req`  in  1  DMA wants a beat
- `dma_we`  in  1  DMA beat is a write
- `dma_addr`  in  ADDR_W  DMA address
- `dma_wdata`  in  DATA_W  DMA write data
- `dma_gnt`  out  1  DMA beat accepted this cycle
- `dma_rvalid`  out  1  registered; `dma_rdata` is valid
- `dma_rdata`  out  DATA_W  registered read data for the previous accepted DMA read
- `mem_addr`  out  ADDR_W  to Memory address
- `mem_wd`  out  DATA_W  to Memory write data
- `mem_we`  out  1  to Memory write enable
- `mem_rd`  in  DATA_W  from Memory; combinational read
- `owner`  out  1  0 = CPU, 1 = DMA; equals the state bit

## Operation
- FSM has two states: S_CPU and S_DMA. Registered counters:
  - `starve_cnt`: 0..STARVE_LIMIT-1
  - `beat_cnt`: 0..BURST_LEN-1
- Port mux (combinational on state):
  - S_CPU: `mem_addr`/`mem_wd` come from the cpu_* inputs; `mem_we = cpu_req & cpu_we`.
  - S_DMA: `mem_addr`/`mem_wd` come from the dma_* inputs; `mem_we = dma_req & dma_we`.
- Outputs:
  - `cpu_stall = cpu_req & (state == S_DMA)`.
  - `dma_gnt = dma_req & (state == S_DMA)`.
- S_CPU transitions:
  - `dma_req & !cpu_req` → S_DMA. The port is idle for that cycle.
  - `dma_req & cpu_req`:
    - The CPU is serviced.
    - If `starve_cnt == STARVE_LIMIT-1`, go to S_DMA.
    - Otherwise increment `starve_cnt`.
  - `!dma_req` → stay in S_CPU and clear `starve_cnt`.
- Entering S_DMA clears `starve_cnt` and `beat_cnt`.
- S_DMA transitions:
  - `dma_req`: the beat is accepted.
    - If `beat_cnt == BURST_LEN-1`, go to S_CPU.
    - Otherwise increment `beat_cnt`.
  - `!dma_req` → S_CPU with no beat, whether or not `cpu_req` is high.
- DMA read return: on an accepted beat with `!dma_we`, at the next edge `dma_rdata <= mem_rd` and `dma_rvalid <= 1`. On any other cycle `dma_rvalid <= 0` and `dma_rdata` holds its value.
- A DMA that re-requests right after a full burst is treated as a new request from S_CPU. It waits for a CPU-idle cycle or for STARVE_LIMIT contended cycles.

## Timing
- Reset values (at the first edge with `reset` high):
  - state = S_CPU, `starve_cnt` = 0, `beat_cnt` = 0.
  - `dma_rvalid` = 0, `dma_rdata` = 0, `owner` = 0.
- While `reset` is high:
  - `mem_we` is forced 0, `dma_gnt` is forced 0, `cpu_stall` is forced 0.
  - No access is serviced, so a write cannot corrupt memory during reset.
- Reset asserted mid-burst: the burst is abandoned with no further beats. The DMA master must re-request.
- CPU access latency:
  - Read data is valid in the same cycle on `cpu_rdata`.
  - A write commits at the next edge, through Memory's synchronous write.
- DMA latency and throughput:
  - First beat comes ≥1 cycle after `dma_req` rises: a bubble cycle if the CPU is idle, or up to STARVE_LIMIT cycles under contention.
  - Read data arrives 1 cycle after `dma_gnt`.
  - Up to BURST_LEN back-to-back beats, one per cycle.
- Worst-case CPU stall is BURST_LEN consecutive cycles per DMA grant.
- DMA handshake: the master holds `dma_addr`, `dma_we` and `dma_wdata` stable until it samples `dma_gnt` = 1 at a clock edge.
- `cpu_rdata` is never registered. `mem_rd` is passed straight through in every state.

## Test plan
- Reset, then `cpu_req` = 1 every cycle with `dma_req` = 0 → `owner` stays 0, `cpu_stall` stays 0, and `mem_we` follows `cpu_we`.
- CPU idle; DMA writes 0xA0..0xAC (4 beats) → 1 bubble cycle, then `dma_gnt` high for 4 consecutive cycles; `owner` returns to 0 after beat 4; memory holds the written data.
- `cpu_req` and `dma_req` both held high, defaults → CPU serviced for 8 cycles, then DMA for 4 beats with `cpu_stall` = 1 during those 4, then CPU again. The pattern repeats.
- DMA read from 0x40 holding 0xDEADBEEF → `dma_rvalid` = 1 with `dma_rdata` = 0xDEADBEEF exactly 1 cycle after `dma_gnt`.
- DMA drops `dma_req` after 2 of 4 beats → S_CPU on the next edge, and `beat_cnt` is cleared on the next grant.
- `reset` asserted during beat 2 of a DMA write burst → `mem_we` = 0 in the reset cycle, `owner` = 0 and `dma_rvalid` = 0 after the edge, and no further beats are granted.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Bundle of signals around the shared memory port.
//   CPU side : cpu_req/cpu_we/cpu_addr/cpu_wdata in, cpu_rdata/cpu_stall out
//   DMA side : dma_req/dma_we/dma_addr/dma_wdata in, dma_gnt/dma_rvalid/dma_rdata out
//   Memory   : mem_addr/mem_wd/mem_we out, mem_rd in (combinational read)
//   owner    : current port owner (0 = CPU, 1 = DMA)
// slave  = arbiter's view, master = view of the surrounding core/DMA/memory.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_stall;
  logic              dma_req;
  logic              dma_we;
  logic [ADDR_W-1:0] dma_addr;
  logic [DATA_W-1:0] dma_wdata;
  logic              dma_gnt;
  logic              dma_rvalid;
  logic [DATA_W-1:0] dma_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wd;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rd;
  logic              owner;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_stall,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    output dma_gnt, dma_rvalid, dma_rdata,
    output mem_addr, mem_wd, mem_we,
    input  mem_rd,
    output owner
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_stall,
    output dma_req, dma_we, dma_addr, dma_wdata,
    input  dma_gnt, dma_rvalid, dma_rdata,
    input  mem_addr, mem_wd, mem_we,
    output mem_rd,
    input  owner
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for the unified memory of the multi-cycle MIPS core.
// The CPU owns the port by default; DMA gets bounded bursts of up to
// BURST_LEN beats, and is forced in after STARVE_LIMIT contended cycles.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous, active-high
//   bus   : mem_port_arbiter_if.slave (CPU, DMA and Memory signal groups)
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 8,
  parameter int BURST_LEN    = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  mem_port_arbiter_if.slave    bus
);

  localparam int SW = (STARVE_LIMIT > 1) ? $clog2(STARVE_LIMIT) : 1;
  localparam int BW = (BURST_LEN > 1)    ? $clog2(BURST_LEN)    : 1;
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT - 1);
  localparam logic [BW-1:0] BEAT_MAX   = BW'(BURST_LEN - 1);

  typedef enum logic {S_CPU = 1'b0, S_DMA = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [SW-1:0]     starve_q, starve_d;
  logic [BW-1:0]     beat_q, beat_d;
  logic              dma_rvalid_q, dma_rvalid_d;
  logic [DATA_W-1:0] dma_rdata_q, dma_rdata_d;
  logic              in_dma;
  logic              gnt;

  assign in_dma = (state_q == S_DMA);
  // Nothing is serviced during reset, so memory cannot be corrupted.
  assign gnt    = ~reset & bus.dma_req & in_dma;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_CPU;
      starve_q     <= '0;
      beat_q       <= '0;
      dma_rvalid_q <= 1'b0;
      dma_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      starve_q     <= starve_d;
      beat_q       <= beat_d;
      dma_rvalid_q <= dma_rvalid_d;
      dma_rdata_q  <= dma_rdata_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    beat_d   = beat_q;
    case (state_q)
      S_CPU: begin
        // Holding beat_cnt at 0 here means every grant starts a fresh burst.
        beat_d = '0;
        if (!bus.dma_req) begin
          starve_d = '0;
        end else if (!bus.cpu_req || starve_q == STARVE_MAX) begin
          // Idle CPU cycle (port left idle this cycle) or starvation limit hit.
          state_d  = S_DMA;
          starve_d = '0;
        end else begin
          starve_d = starve_q + SW'(1);
        end
      end
      S_DMA: begin
        starve_d = '0;
        if (bus.dma_req && beat_q != BEAT_MAX) begin
          beat_d = beat_q + BW'(1);
        end else begin
          // Burst complete, or DMA went quiet: hand the port back.
          state_d = S_CPU;
          beat_d  = '0;
        end
      end
      default: begin
        state_d  = S_CPU;
        starve_d = '0;
        beat_d   = '0;
      end
    endcase
  end

  // Capture read data of an accepted DMA read beat; hold otherwise.
  always_comb begin
    dma_rvalid_d = gnt & ~bus.dma_we;
    dma_rdata_d  = dma_rvalid_d ? bus.mem_rd : dma_rdata_q;
  end

  assign bus.mem_addr   = in_dma ? bus.dma_addr  : bus.cpu_addr;
  assign bus.mem_wd     = in_dma ? bus.dma_wdata : bus.cpu_wdata;
  assign bus.mem_we     = ~reset & (in_dma ? (bus.dma_req & bus.dma_we)
                                           : (bus.cpu_req & bus.cpu_we));
  assign bus.cpu_rdata  = bus.mem_rd;
  assign bus.cpu_stall  = ~reset & bus.cpu_req & in_dma;
  assign bus.dma_gnt    = gnt;
  assign bus.dma_rvalid = dma_rvalid_q;
  assign bus.dma_rdata  = dma_rdata_q;
  assign bus.owner      = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus();

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(8), .BURST_LEN(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Word-addressed memory with combinational read and synchronous write.
  logic [31:0] mem [256];
  bit          loaded = 1'b0;
  assign bus.mem_rd = mem[bus.mem_addr[9:2]];
  always @(posedge clk) begin
    if (!loaded) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
      mem[16] <= 32'hDEADBEEF;
      mem[17] <= 32'h0BADF00D;
      loaded  <= 1'b1;
    end else if (bus.mem_we) begin
      mem[bus.mem_addr[9:2]] <= bus.mem_wd;
    end
  end

  task automatic idle_inputs();
    bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.dma_req = 0; bus.dma_we = 0; bus.dma_addr = '0; bus.dma_wdata = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1; bus.cpu_req = 1; bus.cpu_we = 1; bus.dma_req = 1; bus.dma_we = 1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk); #1;
      total++; if (bus.mem_we !== 1'b0) begin bad++; $display("FAIL rst_mem_we got=%b exp=0", bus.mem_we); end
      total++; if (bus.dma_gnt !== 1'b0) begin bad++; $display("FAIL rst_gnt got=%b exp=0", bus.dma_gnt); end
      total++; if (bus.cpu_stall !== 1'b0) begin bad++; $display("FAIL rst_stall got=%b exp=0", bus.cpu_stall); end
      total++; if (bus.owner !== 1'b0) begin bad++; $display("FAIL rst_owner got=%b exp=0", bus.owner); end
      total++; if (bus.dma_rvalid !== 1'b0) begin bad++; $display("FAIL rst_rvalid got=%b exp=0", bus.dma_rvalid); end
      total++; if (bus.dma_rdata !== 32'h0) begin bad++; $display("FAIL rst_rdata got=%h exp=0", bus.dma_rdata); end
    end
    @(negedge clk);
    reset = 0;
    idle_inputs();
  endtask

  task automatic test_cpu_only();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      bus.cpu_req = 1; bus.cpu_we = i[0];
      bus.cpu_addr = 32'h100 + 32'(4*i); bus.cpu_wdata = 32'h5000 + 32'(i);
      #1;
      total++; if (bus.owner !== 1'b0) begin bad++; $display("FAIL cpu_owner i=%0d got=%b exp=0", i, bus.owner); end
      total++; if (bus.cpu_stall !== 1'b0) begin bad++; $display("FAIL cpu_stall i=%0d got=%b exp=0", i, bus.cpu_stall); end
      total++; if (bus.mem_we !== i[0]) begin bad++; $display("FAIL cpu_mem_we i=%0d got=%b exp=%b", i, bus.mem_we, i[0]); end
      total++; if (bus.mem_addr !== 32'h100 + 32'(4*i)) begin bad++; $display("FAIL cpu_mem_addr i=%0d got=%h", i, bus.mem_addr); end
    end
    @(negedge clk);
    bus.cpu_we = 0; bus.cpu_addr = 32'h10C; #1;
    total++; if (bus.cpu_rdata !== 32'h5003) begin bad++; $display("FAIL cpu_readback got=%h exp=00005003", bus.cpu_rdata); end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_dma_write_burst();
    @(negedge clk);
    bus.dma_req = 1; bus.dma_we = 1; bus.dma_addr = 32'hA0; bus.dma_wdata = 32'h1111_0000; #1;
    total++; if (bus.dma_gnt !== 1'b0) begin bad++; $display("FAIL wb_bubble_gnt got=%b exp=0", bus.dma_gnt); end
    total++; if (bus.mem_we !== 1'b0) begin bad++; $display("FAIL wb_bubble_we got=%b exp=0", bus.mem_we); end
    for (int b = 0; b < 4; b++) begin
      @(negedge clk);
      bus.dma_addr = 32'hA0 + 32'(4*b); bus.dma_wdata = 32'h1111_0000 + 32'(b); #1;
      total++; if (bus.dma_gnt !== 1'b1) begin bad++; $display("FAIL wb_gnt b=%0d got=%b exp=1", b, bus.dma_gnt); end
      total++; if (bus.owner !== 1'b1) begin bad++; $display("FAIL wb_owner b=%0d got=%b exp=1", b, bus.owner); end
      total++; if (bus.mem_we !== 1'b1) begin bad++; $display("FAIL wb_we b=%0d got=%b exp=1", b, bus.mem_we); end
      total++; if (bus.mem_addr !== 32'hA0 + 32'(4*b)) begin bad++; $display("FAIL wb_addr b=%0d got=%h", b, bus.mem_addr); end
    end
    @(negedge clk);
    bus.dma_req = 0; #1;
    total++; if (bus.owner !== 1'b0) begin bad++; $display("FAIL wb_owner_after got=%b exp=0", bus.owner); end
    for (int b = 0; b < 4; b++) begin
      total++; if (mem[40+b] !== 32'h1111_0000 + 32'(b)) begin bad++; $display("FAIL wb_mem b=%0d got=%h", b, mem[40+b]); end
    end
    idle_inputs();
  endtask

  task automatic test_contention();
    bit exp_dma, exp_rv;
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 32'h10C;
      bus.dma_req = 1; bus.dma_we = 0; bus.dma_addr = 32'h44; #1;
      exp_dma = (c % 12) >= 8;
      exp_rv  = (c > 0) && (((c - 1) % 12) >= 8);
      total++; if (bus.owner !== exp_dma) begin bad++; $display("FAIL ct_owner c=%0d got=%b exp=%b", c, bus.owner, exp_dma); end
      total++; if (bus.cpu_stall !== exp_dma) begin bad++; $display("FAIL ct_stall c=%0d got=%b exp=%b", c, bus.cpu_stall, exp_dma); end
      total++; if (bus.dma_gnt !== exp_dma) begin bad++; $display("FAIL ct_gnt c=%0d got=%b exp=%b", c, bus.dma_gnt, exp_dma); end
      total++; if (bus.cpu_rdata !== (exp_dma ? 32'h0BADF00D : 32'h5003)) begin bad++; $display("FAIL ct_rdata c=%0d got=%h", c, bus.cpu_rdata); end
      total++; if (bus.dma_rvalid !== exp_rv) begin bad++; $display("FAIL ct_rvalid c=%0d got=%b exp=%b", c, bus.dma_rvalid, exp_rv); end
      if (exp_rv) begin
        total++; if (bus.dma_rdata !== 32'h0BADF00D) begin bad++; $display("FAIL ct_dma_rdata c=%0d got=%h exp=0badf00d", c, bus.dma_rdata); end
      end
    end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_dma_read();
    @(negedge clk);
    bus.dma_req = 1; bus.dma_we = 0; bus.dma_addr = 32'h40; #1;
    total++; if (bus.dma_gnt !== 1'b0) begin bad++; $display("FAIL rd_bubble got=%b exp=0", bus.dma_gnt); end
    @(negedge clk); #1;
    total++; if (bus.dma_gnt !== 1'b1) begin bad++; $display("FAIL rd_gnt got=%b exp=1", bus.dma_gnt); end
    total++; if (bus.dma_rvalid !== 1'b0) begin bad++; $display("FAIL rd_rvalid_early got=%b exp=0", bus.dma_rvalid); end
    @(negedge clk);
    bus.dma_req = 0; #1;
    total++; if (bus.dma_rvalid !== 1'b1) begin bad++; $display("FAIL rd_rvalid got=%b exp=1", bus.dma_rvalid); end
    total++; if (bus.dma_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL rd_rdata got=%h exp=deadbeef", bus.dma_rdata); end
    total++; if (bus.owner !== 1'b1) begin bad++; $display("FAIL rd_owner_hold got=%b exp=1", bus.owner); end
    @(negedge clk); #1;
    total++; if (bus.owner !== 1'b0) begin bad++; $display("FAIL rd_owner_back got=%b exp=0", bus.owner); end
    total++; if (bus.dma_rvalid !== 1'b0) begin bad++; $display("FAIL rd_rvalid_drop got=%b exp=0", bus.dma_rvalid); end
    total++; if (bus.dma_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL rd_rdata_hold got=%h exp=deadbeef", bus.dma_rdata); end
    idle_inputs();
  endtask

  task automatic test_early_drop();
    @(negedge clk);
    bus.dma_req = 1; bus.dma_we = 1; bus.dma_addr = 32'hC0; bus.dma_wdata = 32'hC000_0000; #1;
    total++; if (bus.dma_gnt !== 1'b0) begin bad++; $display("FAIL ed_bubble got=%b exp=0", bus.dma_gnt); end
    for (int b = 0; b < 2; b++) begin
      @(negedge clk);
      bus.dma_addr = 32'hC0 + 32'(4*b); bus.dma_wdata = 32'hC000_0000 + 32'(b); #1;
      total++; if (bus.dma_gnt !== 1'b1) begin bad++; $display("FAIL ed_gnt b=%0d got=%b exp=1", b, bus.dma_gnt); end
    end
    @(negedge clk);
    bus.dma_req = 0; #1;
    total++; if (bus.owner !== 1'b1) begin bad++; $display("FAIL ed_owner_drop got=%b exp=1", bus.owner); end
    total++; if (bus.mem_we !== 1'b0) begin bad++; $display("FAIL ed_we_drop got=%b exp=0", bus.mem_we); end
    @(negedge clk); #1;
    total++; if (bus.owner !== 1'b0) begin bad++; $display("FAIL ed_owner_back got=%b exp=0", bus.owner); end
    @(negedge clk);
    bus.dma_req = 1; bus.dma_addr = 32'hD0; bus.dma_wdata = 32'hD000_0000; #1;
    total++; if (bus.dma_gnt !== 1'b0) begin bad++; $display("FAIL ed_rebubble got=%b exp=0", bus.dma_gnt); end
    for (int b = 0; b < 4; b++) begin
      @(negedge clk);
      bus.dma_addr = 32'hD0 + 32'(4*b); bus.dma_wdata = 32'hD000_0000 + 32'(b); #1;
      total++; if (bus.dma_gnt !== 1'b1) begin bad++; $display("FAIL ed_regnt b=%0d got=%b exp=1", b, bus.dma_gnt); end
    end
    @(negedge clk);
    bus.dma_req = 0; #1;
    total++; if (bus.owner !== 1'b0) begin bad++; $display("FAIL ed_owner_end got=%b exp=0", bus.owner); end
    idle_inputs();
  endtask

  task automatic test_reset_mid_burst();
    @(negedge clk);
    bus.dma_req = 1; bus.dma_we = 1; bus.dma_addr = 32'hE0; bus.dma_wdata = 32'hE0E0; #1;
    @(negedge clk); #1;
    total++; if (bus.dma_gnt !== 1'b1) begin bad++; $display("FAIL rm_beat1 got=%b exp=1", bus.dma_gnt); end
    @(negedge clk);
    bus.dma_addr = 32'hE4; bus.dma_wdata = 32'hE4E4; bus.cpu_req = 1; bus.cpu_we = 1;
    reset = 1; #1;
    total++; if (bus.mem_we !== 1'b0) begin bad++; $display("FAIL rm_we got=%b exp=0", bus.mem_we); end
    total++; if (bus.dma_gnt !== 1'b0) begin bad++; $display("FAIL rm_gnt got=%b exp=0", bus.dma_gnt); end
    total++; if (bus.cpu_stall !== 1'b0) begin bad++; $display("FAIL rm_stall got=%b exp=0", bus.cpu_stall); end
    @(negedge clk);
    reset = 0; idle_inputs(); #1;
    total++; if (bus.owner !== 1'b0) begin bad++; $display("FAIL rm_owner got=%b exp=0", bus.owner); end
    total++; if (bus.dma_rvalid !== 1'b0) begin bad++; $display("FAIL rm_rvalid got=%b exp=0", bus.dma_rvalid); end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk); #1;
      total++; if (bus.dma_gnt !== 1'b0) begin bad++; $display("FAIL rm_nobeat k=%0d got=%b exp=0", k, bus.dma_gnt); end
    end
    total++; if (mem[56] !== 32'hE0E0) begin bad++; $display("FAIL rm_mem_beat1 got=%h exp=0000e0e0", mem[56]); end
    total++; if (mem[57] !== 32'h0) begin bad++; $display("FAIL rm_mem_beat2 got=%h exp=00000000", mem[57]); end
  endtask

  initial begin
    test_reset();
    test_cpu_only();
    test_dma_write_burst();
    test_contention();
    test_dma_read();
    test_early_drop();
    test_reset_mid_burst();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
